// File: rtl/uart_receiver.sv
// UART receive path: synchronizes rxd, recovers one character per frame using an
// oversampling tick, and presents it on a valid/ready port with sticky error flags.
module uart_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sampleTick,
  input  logic                  rxd,
  input  logic [4:0]            cfgOverSampling,
  input  logic [3:0]            cfgDataType,
  input  logic                  cfgParityEnable,
  input  logic                  cfgParityType,
  input  logic [1:0]            cfgStopBits,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  input  logic                  rxReady,
  output logic                  parityError,
  output logic                  framingError,
  output logic                  breakError,
  output logic                  overrunError
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_BREAKWAIT = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;

  logic [2:0]            state_q, state_d;
  logic [4:0]            tick_cnt_q, tick_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bit_q, par_bit_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  stop0_q, stop0_d;

  logic [4:0] os_q, os_d;
  logic [3:0] dt_q, dt_d;
  logic       pen_q, pen_d;
  logic       ptype_q, ptype_d;
  logic       stop2_q, stop2_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_o_q, perr_o_d;
  logic                  ferr_o_q, ferr_o_d;
  logic                  brk_o_q, brk_o_d;
  logic                  ovr_q, ovr_d;

  logic       done;
  logic       ferr_nxt;
  logic       brk_now;
  logic       last_bit;
  logic [4:0] half_m1;
  logic [4:0] os_m1;
  logic [3:0] dt_m1;

  assign rxd_s   = sync_q[SYNC_STAGES-1];
  assign half_m1 = (os_q >> 1) - 5'd1;
  assign os_m1   = os_q - 5'd1;
  assign dt_m1   = dt_q - 4'd1;
  // bit_idx saturates at 7, so an out-of-range data type still terminates the frame
  assign last_bit = ({1'b0, bit_idx_q} == dt_m1) || (bit_idx_q == 3'd7);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop0_d    = stop0_q;
    os_d       = os_q;
    dt_d       = dt_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    stop2_d    = stop2_q;
    done       = 1'b0;
    ferr_nxt   = ferr_q | ~rxd_s;
    brk_now    = (shreg_q == '0) && !par_bit_q &&
                 !((stop_idx_q == 1'b0) ? rxd_s : stop0_q);

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d    = S_START;
          tick_cnt_d = 5'd0;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          shreg_d    = '0;
          par_bit_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop0_d    = 1'b1;
          os_d       = cfgOverSampling;
          dt_d       = cfgDataType;
          pen_d      = cfgParityEnable;
          ptype_d    = cfgParityType;
          stop2_d    = (cfgStopBits == 2'd2);
        end
      end
      S_START: begin
        if (sampleTick) begin
          if (tick_cnt_q == half_m1) begin
            tick_cnt_d = 5'd0;
            bit_idx_d  = 3'd0;
            state_d    = rxd_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (sampleTick) begin
          if (tick_cnt_q == os_m1) begin
            tick_cnt_d         = 5'd0;
            shreg_d[bit_idx_q] = rxd_s;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (last_bit) state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      S_PARITY: begin
        if (sampleTick) begin
          if (tick_cnt_q == os_m1) begin
            tick_cnt_d = 5'd0;
            par_bit_d  = rxd_s;
            perr_d     = (^shreg_q) ^ rxd_s ^ ptype_q;
            stop_idx_d = 1'b0;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (sampleTick) begin
          if (tick_cnt_q == os_m1) begin
            tick_cnt_d = 5'd0;
            ferr_d     = ferr_nxt;
            if (stop_idx_q == 1'b0) stop0_d = rxd_s;
            if (stop2_q && (stop_idx_q == 1'b0)) begin
              stop_idx_d = 1'b1;
            end else begin
              done    = 1'b1;
              state_d = ferr_nxt ? S_BREAKWAIT : S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      S_BREAKWAIT: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    brk_o_d  = brk_o_q;
    ovr_d    = ovr_q;
    if (done) begin
      if (!valid_q || rxReady) begin
        data_d   = shreg_q;
        valid_d  = 1'b1;
        perr_o_d = pen_q & perr_q;
        ferr_o_d = ferr_nxt;
        brk_o_d  = brk_now;
        ovr_d    = 1'b0;
      end else begin
        // held word wins; the new frame is dropped and only flagged
        ovr_d = 1'b1;
      end
    end else if (valid_q && rxReady) begin
      valid_d  = 1'b0;
      perr_o_d = 1'b0;
      ferr_o_d = 1'b0;
      brk_o_d  = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      tick_cnt_q <= 5'd0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop0_q    <= 1'b1;
      os_q       <= 5'd16;
      dt_q       <= 4'd8;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_o_q   <= 1'b0;
      ferr_o_q   <= 1'b0;
      brk_o_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop0_q    <= stop0_d;
      os_q       <= os_d;
      dt_q       <= dt_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_o_q   <= perr_o_d;
      ferr_o_q   <= ferr_o_d;
      brk_o_q    <= brk_o_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rxData       = data_q;
  assign rxValid      = valid_q;
  assign parityError  = perr_o_q;
  assign framingError = ferr_o_q;
  assign breakError   = brk_o_q;
  assign overrunError = ovr_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive path; the receiving end of the frames produced by the UART transmitter (start, data LSB-first, optional parity, 1-2 stop bits).
- Samples the asynchronous rxd line using an oversampling tick.
- Recovers each character and checks parity, framing and break.
- Presents each word on a valid/ready interface with sticky error flags, for the UART RX monitor and driver BFMs and the DUT-side RX path.

Parameters:
DATA_WIDTH, 8, width of rxData; maximum character length.
SYNC_STAGES, 2, flops in the rxd synchronizer (minimum 2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
sampleTick  input  1  one-clk pulse at baudRate*overSampling (OverSampledBaudFrequencyClk enable).
rxd  input  1  serial line, idle high, asynchronous.
cfgOverSampling  input  5  16 or 13 (overSamplingEnum).
cfgDataType  input  4  5..8 data bits (dataTypeEnum).
cfgParityEnable  input  1  1 = parity bit present.
cfgParityType  input  1  0 = EVEN_PARITY, 1 = ODD_PARITY.
cfgStopBits  input  2  1 = ONE_BIT, 2 = TWO_BIT.
rxData  output  DATA_WIDTH  received character, LSB-aligned, upper bits zero.
rxValid  output  1  rxData and flags valid.
rxReady  input  1  consumer accepts the word when rxValid && rxReady.
parityError  output  1  parity mismatch for the held word.
framingError  output  1  a stop-bit sample was 0.
breakError  output  1  line low for the whole frame.
overrunError  output  1  at least one frame was lost while the word was held.

Behaviour:
Reset (synchronous, sampled on clk):
- Synchronizer flops go to 1; state goes to IDLE; counters clear.
- All outputs go to 0.
- Reset mid-frame abandons the frame with no output.

Sampling and config:
- All line decisions use the synchronized rxd (rxdS) only. Counters advance only on cycles where sampleTick = 1.
- Config is latched on the IDLE->START transition. Config changes mid-frame have no effect until the next frame.
- half = cfgOverSampling >> 1 (8 for 16, 6 for 13).

State machine (states IDLE, START, DATA, PARITY, STOP, BREAKWAIT):
- IDLE: rxdS == 0 -> START; tickCnt = 0.
- START: at tick with tickCnt == half-1, sample rxdS. If 0 -> DATA (tickCnt = 0, bitIdx = 0). If 1 -> IDLE (false start; no output, no flags).
- DATA: at tick with tickCnt == os-1, sample into shift register LSB-first and set tickCnt = 0. After sampling bit dataType-1: go to PARITY if parity is enabled, else STOP.
- PARITY: sample at tickCnt == os-1. perr = XOR(data bits, parity bit) XOR cfgParityType; for odd parity the total XOR must be 1.
- STOP: sample cfgStopBits stop bits, each at tickCnt == os-1. ferr = any stop sample == 0.
- Break: brk = all data bits 0 AND parity bit 0 (if enabled) AND first stop sample 0.
- After the last stop sample: complete the frame. Then go to BREAKWAIT if ferr, else IDLE.
- BREAKWAIT: wait for rxdS == 1, then go to IDLE. A held-low line never triggers a false new frame.

Frame completion (the clk cycle after the final stop sample tick):
- If rxValid == 0, or rxValid && rxReady in the same cycle: load rxData, parityError, framingError and breakError. Set rxValid = 1 and overrunError = 0.
- Else (word still held): discard the new frame; set overrunError = 1. Held data and other flags are unchanged.

Handshake:
- rxValid && rxReady with no completion in that cycle: clear rxValid and all four flags on the next clk.
- rxValid and all outputs stay stable while rxValid && !rxReady.

Latency and counter widths:
- Start edge to rxValid ~= (1 + dataType + parity + stopBits - 0.5) bit times + SYNC_STAGES + 1 clk.
- tickCnt is 5 bits and wraps only via explicit clear.
- bitIdx is 3 bits.

Test Plan:
- 8N1, OS16, send 0xA5, rxReady = 1 -> one rxValid pulse, rxData = 0xA5, all flags 0; rxValid arrives 9.5 bit times after start (+-1 tick + sync).
- 7E1, OS13, send 0x35 with parity bit forced to 1 -> rxData = 0x35, parityError = 1. Repeat with correct parity 0 -> parityError = 0.
- rxd low pulse of 4 ticks, then high -> no rxValid; FSM returns to IDLE. A following 0x3C frame is received correctly.
- 8N2, 0x81, second stop bit 0 -> rxData = 0x81, framingError = 1, breakError = 0.
- Line held low for 3 frame times, then high -> exactly one word: rxData = 0x00, framingError = 1, breakError = 1. Next frame 0x5A is received cleanly.
- rxReady = 0, send 0x11 then 0x22 -> rxData stays 0x11 with overrunError = 1. Assert rxReady -> rxValid drops and flags clear. Reset asserted mid-frame -> all outputs 0 and no word produced.
